// File: rtl/note_stack_lnp.sv
// Monophonic last-note-priority key stack: tracks up to DEPTH held keys and
// drives gate/note/velocity/retrig for the pitch and envelope path.

module note_stack_cmp (
  input  logic [6:0] key_i,
  input  logic [6:0] note_i,
  input  logic       valid_i,
  output logic       hit_o
);
  assign hit_o = valid_i && (key_i == note_i);
endmodule

module note_stack_lnp #(
  parameter int         DEPTH   = 8,
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         LEGATO  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_stb,
  input  logic [3:0] ch_message,
  input  logic [3:0] chan,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  input  logic [6:0] lsb,
  output logic       gate,
  output logic [6:0] note_out,
  output logic [6:0] vel_out,
  output logic       retrig,
  output logic [4:0] count
);
  typedef struct packed {
    logic [6:0] note;
    logic [6:0] vel;
  } entry_t;

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  entry_t [DEPTH-1:0] stk_q, stk_d, shf;
  logic [DEPTH-1:0]   hit;
  logic [4:0]         cnt_q, cnt_d, base;
  logic               gate_q, gate_d, retrig_q, retrig_d;
  logic [6:0]         nout_q, nout_d, vout_q, vout_d;
  logic               acc, is_on, is_off, is_ano, found, full;
  int                 fidx;

  // Only live slots (below count) can match, so stale entries are harmless.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    note_stack_cmp u_cmp (
      .key_i  (stk_q[i].note),
      .note_i (note),
      .valid_i(5'(i) < cnt_q),
      .hit_o  (hit[i])
    );
  end

  assign found  = |hit;
  assign full   = (cnt_q == DEPTH_C);
  assign acc    = msg_stb && (OMNI || chan == CHANNEL);
  assign is_on  = (ch_message == 4'b1001) && (velocity != 7'd0);
  assign is_off = (ch_message == 4'b1000) || ((ch_message == 4'b1001) && (velocity == 7'd0));
  assign is_ano = (ch_message == 4'b1011) && (lsb == 7'd120 || lsb == 7'd123);

  always_comb begin
    fidx = 0;
    for (int i = 0; i < DEPTH; i++)
      if (hit[i]) fidx = i;
  end

  // Compacted stack with entry fidx removed; fidx=0 on a miss doubles as
  // the drop-oldest shift for a note-on into a full stack.
  always_comb begin
    shf = stk_q;
    for (int i = 0; i < DEPTH-1; i++)
      if (i >= fidx) shf[i] = stk_q[i+1];
  end

  always_comb begin
    stk_d    = stk_q;
    cnt_d    = cnt_q;
    gate_d   = gate_q;
    nout_d   = nout_q;
    vout_d   = vout_q;
    retrig_d = 1'b0;
    base     = cnt_q;
    if (acc) begin
      if (is_on) begin
        if (found || full) begin
          stk_d = shf;
          base  = cnt_q - 5'd1;
        end
        for (int i = 0; i < DEPTH; i++)
          if (5'(i) == base) stk_d[i] = {note, velocity};
        cnt_d    = base + 5'd1;
        gate_d   = 1'b1;
        nout_d   = note;
        vout_d   = velocity;
        retrig_d = !(LEGATO && gate_q);
      end else if (is_off && found) begin
        stk_d  = shf;
        cnt_d  = cnt_q - 5'd1;
        gate_d = (cnt_d != 5'd0);
        // Empty stack keeps the last pitch for the release phase.
        for (int i = 0; i < DEPTH; i++)
          if (5'(i) + 5'd1 == cnt_d) begin
            nout_d = shf[i].note;
            vout_d = shf[i].vel;
          end
      end else if (is_ano) begin
        cnt_d  = 5'd0;
        gate_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_q    <= '0;
      cnt_q    <= 5'd0;
      gate_q   <= 1'b0;
      nout_q   <= 7'd0;
      vout_q   <= 7'd0;
      retrig_q <= 1'b0;
    end else begin
      stk_q    <= stk_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      nout_q   <= nout_d;
      vout_q   <= vout_d;
      retrig_q <= retrig_d;
    end
  end

  assign gate     = gate_q;
  assign note_out = nout_q;
  assign vel_out  = vout_q;
  assign retrig   = retrig_q;
  assign count    = cnt_q;
endmodule

// File: tb/tb_note_stack_lnp.sv
// Bench for note_stack_lnp: three instances (omni, channel-filtered, legato)
// checked against a queue-based key-stack model plus hand-computed vectors.

module tb_note_stack_lnp;
  logic clk, rst_n, msg_stb;
  logic [3:0] ch_message, chan;
  logic [6:0] note, velocity, lsb;
  logic [2:0]      gate_w, retrig_w;
  logic [2:0][6:0] note_w, vel_w;
  logic [2:0][4:0] count_w;
  int n_assert = 0;
  int n_fail   = 0;

  note_stack_lnp u_main (
    .clk(clk), .rst_n(rst_n), .msg_stb(msg_stb), .ch_message(ch_message), .chan(chan),
    .note(note), .velocity(velocity), .lsb(lsb), .gate(gate_w[0]), .note_out(note_w[0]),
    .vel_out(vel_w[0]), .retrig(retrig_w[0]), .count(count_w[0]));
  note_stack_lnp #(.OMNI(1'b0), .CHANNEL(4'd2)) u_chan (
    .clk(clk), .rst_n(rst_n), .msg_stb(msg_stb), .ch_message(ch_message), .chan(chan),
    .note(note), .velocity(velocity), .lsb(lsb), .gate(gate_w[1]), .note_out(note_w[1]),
    .vel_out(vel_w[1]), .retrig(retrig_w[1]), .count(count_w[1]));
  note_stack_lnp #(.LEGATO(1'b1)) u_leg (
    .clk(clk), .rst_n(rst_n), .msg_stb(msg_stb), .ch_message(ch_message), .chan(chan),
    .note(note), .velocity(velocity), .lsb(lsb), .gate(gate_w[2]), .note_out(note_w[2]),
    .vel_out(vel_w[2]), .retrig(retrig_w[2]), .count(count_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: held keys as a queue, oldest at the front.
  logic [13:0] mq[3][$];
  logic        mgate[3], mret[3];
  logic [6:0]  mnote[3], mvel[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mgate[k] = 0; mret[k] = 0; mnote[k] = 0; mvel[k] = 0;
    end
  endtask

  function automatic int mfind(int k, logic [6:0] n);
    for (int i = 0; i < mq[k].size(); i++)
      if (mq[k][i][13:7] == n) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit acc;
    int f;
    for (int k = 0; k < 3; k++) begin
      acc = msg_stb && ((k != 1) || chan == 4'd2);
      mret[k] = 0;
      if (acc) begin
        if (ch_message == 4'b1001 && velocity != 0) begin
          f = mfind(k, note);
          if (f >= 0) mq[k].delete(f);
          else if (mq[k].size() == 8) mq[k].delete(0);
          mq[k].push_back({note, velocity});
          mret[k] = !(k == 2 && mgate[k]);
          mgate[k] = 1; mnote[k] = note; mvel[k] = velocity;
        end else if (ch_message == 4'b1000 || ch_message == 4'b1001) begin
          f = mfind(k, note);
          if (f >= 0) begin
            mq[k].delete(f);
            if (mq[k].size() > 0) {mnote[k], mvel[k]} = mq[k][mq[k].size()-1];
          end
          mgate[k] = (mq[k].size() > 0);
        end else if (ch_message == 4'b1011 && (lsb == 7'd120 || lsb == 7'd123)) begin
          mq[k].delete();
          mgate[k] = 0;
        end
      end
    end
  endtask

  task automatic check(int k, string nm);
    n_assert++;
    if (gate_w[k] !== mgate[k] || note_w[k] !== mnote[k] || vel_w[k] !== mvel[k] ||
        retrig_w[k] !== mret[k] || count_w[k] !== 5'(mq[k].size())) begin
      n_fail++;
      $display("FAIL %s dut%0d: got g=%b n=%0d v=%0d r=%b c=%0d, want g=%b n=%0d v=%0d r=%b c=%0d",
               nm, k, gate_w[k], note_w[k], vel_w[k], retrig_w[k], count_w[k],
               mgate[k], mnote[k], mvel[k], mret[k], mq[k].size());
    end
  endtask

  task automatic expect_eq(string nm, int got, int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic step(logic stb, logic [3:0] m, logic [3:0] c, logic [6:0] n,
                      logic [6:0] v, logic [6:0] l, string nm);
    msg_stb = stb; ch_message = m; chan = c; note = n; velocity = v; lsb = l;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) check(k, nm);
    msg_stb = 1'b0;
  endtask

  typedef struct {
    logic       stb;
    logic [3:0] m;
    logic [6:0] n, v, l;
    logic       eg;
    logic [6:0] en, ev;
    logic       er;
    logic [4:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(logic stb, logic [3:0] m, logic [6:0] n, logic [6:0] v, logic [6:0] l,
                     logic eg, logic [6:0] en, logic [6:0] ev, logic er, logic [4:0] ec);
    vec_t r;
    r.stb = stb; r.m = m; r.n = n; r.v = v; r.l = l;
    r.eg = eg; r.en = en; r.ev = ev; r.er = er; r.ec = ec;
    tbl.push_back(r);
  endtask

  int r;
  logic [3:0] rm;

  initial begin
    // Basic note-on, stack fallback, hold on empty
    add(1, 4'h9, 60, 100, 0, 1, 60, 100, 1, 1);
    add(1, 4'h9, 64,  90, 0, 1, 64,  90, 1, 2);
    add(1, 4'h9, 67,  80, 0, 1, 67,  80, 1, 3);
    add(1, 4'h8, 67,  64, 0, 1, 64,  90, 0, 2);
    add(1, 4'h8, 64,  64, 0, 1, 60, 100, 0, 1);
    add(1, 4'h8, 60,  64, 0, 0, 60, 100, 0, 0);
    add(0, 4'h9, 70,  50, 0, 0, 60, 100, 0, 0);
    // Overflow: 9 keys into 8 slots drops note 40
    for (int j = 0; j < 9; j++)
      add(1, 4'h9, 7'(40+j), 7'(10+j), 0, 1, 7'(40+j), 7'(10+j), 1, 5'((j < 8) ? j+1 : 8));
    for (int j = 8; j >= 1; j--)
      add(1, 4'h8, 7'(40+j), 0, 0, j > 1, 7'((j > 1) ? 39+j : 41), 7'((j > 1) ? 9+j : 11), 0, 5'(j-1));
    add(1, 4'h8, 40, 0, 0, 0, 41, 11, 0, 0);
    // Re-press, ignored messages, vel-0 note-on as off
    add(1, 4'h9, 60, 70, 0, 1, 60, 70, 1, 1);
    add(1, 4'h9, 62, 72, 0, 1, 62, 72, 1, 2);
    add(1, 4'h9, 60, 74, 0, 1, 60, 74, 1, 2);
    add(1, 4'h8, 60,  0, 0, 1, 62, 72, 0, 1);
    add(1, 4'hB,  0,  0, 7, 1, 62, 72, 0, 1);
    add(1, 4'hC, 33,  0, 0, 1, 62, 72, 0, 1);
    add(1, 4'hA, 62,  5, 0, 1, 62, 72, 0, 1);
    add(1, 4'h8, 99,  0, 0, 1, 62, 72, 0, 1);
    add(1, 4'h9, 62,  0, 0, 0, 62, 72, 0, 0);

    rst_n = 1'b0; msg_stb = 0; ch_message = 0; chan = 0; note = 0; velocity = 0; lsb = 0;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) check(k, "reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].stb, tbl[i].m, 4'd0, tbl[i].n, tbl[i].v, tbl[i].l, "tbl_model");
      n_assert++;
      if (gate_w[0] !== tbl[i].eg || note_w[0] !== tbl[i].en || vel_w[0] !== tbl[i].ev ||
          retrig_w[0] !== tbl[i].er || count_w[0] !== tbl[i].ec) begin
        n_fail++;
        $display("FAIL tbl[%0d]: got g=%b n=%0d v=%0d r=%b c=%0d, want g=%b n=%0d v=%0d r=%b c=%0d",
                 i, gate_w[0], note_w[0], vel_w[0], retrig_w[0], count_w[0],
                 tbl[i].eg, tbl[i].en, tbl[i].ev, tbl[i].er, tbl[i].ec);
      end
    end

    // Channel filter and all-notes-off
    step(1, 4'h9, 4'd3, 50, 40, 0, "chan3_on");
    expect_eq("chan3_ignored", int'(count_w[1]), 0);
    step(1, 4'h9, 4'd2, 50, 40, 0, "chan2_on");
    expect_eq("chan2_accepted", int'(note_w[1]), 50);
    step(1, 4'h9, 4'd2, 52, 41, 0, "chan2_on2");
    step(1, 4'h9, 4'd2, 54, 42, 0, "chan2_on3");
    expect_eq("chan_count3", int'(count_w[1]), 3);
    step(1, 4'hB, 4'd2, 0, 0, 123, "ano");
    expect_eq("ano_gate", int'(gate_w[1]), 0);
    expect_eq("ano_count", int'(count_w[1]), 0);
    expect_eq("ano_hold", int'(note_w[1]), 54);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      rm = (r < 4) ? 4'h9 : (r < 7) ? 4'h8 : (r == 7) ? 4'hB : 4'(r + 4);
      step($urandom_range(0, 4) != 0, rm, 4'($urandom_range(0, 3)), 7'($urandom_range(50, 61)),
           ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
           ($urandom_range(0, 3) != 0) ? 7'd7 : (($urandom_range(0, 1) != 0) ? 7'd120 : 7'd123),
           "random");
    end

    // Legato and asynchronous reset
    rst_n = 1'b0; #2; model_reset(); rst_n = 1'b1;
    step(1, 4'h9, 4'd0, 60, 90, 0, "leg_on1");
    expect_eq("leg_first_retrig", int'(retrig_w[2]), 1);
    step(1, 4'h9, 4'd0, 62, 91, 0, "leg_on2");
    expect_eq("leg_no_retrig", int'(retrig_w[2]), 0);
    expect_eq("nonleg_retrig", int'(retrig_w[0]), 1);
    step(1, 4'h9, 4'd0, 64, 92, 0, "leg_on3");
    step(1, 4'h9, 4'd0, 65, 93, 0, "leg_on4");
    expect_eq("leg_count4", int'(count_w[2]), 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) check(k, "async_rst");
    #3 rst_n = 1'b1;
    step(1, 4'h9, 4'd2, 70, 20, 0, "post_rst_on");
    expect_eq("post_rst_count", int'(count_w[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
